ram_block_mover: RTL and testbench
==================================

Name: ram_block_mover

Overview:
- Bus master sitting directly upstream of the command-processing RAM. It drives that RAM's slave port (REQ/ADDR/CMD/D_WR in, ACK/D_RD back).
- Executes one block command at a time:
  - FILL: write a constant to LEN consecutive addresses.
  - COPY: read LEN bytes from SRC and write them to DST, ascending.
- Gives the command sequencer a single START/DONE interface in place of per-byte bus traffic.

Parameters:
- AW, 5, address width of the target RAM. Depth is 2**AW.

Ports:
- CLK  in  1  single clock. All logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle command strobe. Accepted only in IDLE.
- OP  in  1  0 = FILL, 1 = COPY. Sampled with START.
- SRC  in  AW  COPY source start address. Sampled with START.
- DST  in  AW  destination start address. Sampled with START.
- LEN  in  AW+1  element count, 0..2**AW. Sampled with START.
- FILL_VAL  in  8  FILL data. Sampled with START.
- BUSY  out  1  high while a command is in progress.
- DONE  out  1  one-cycle completion pulse.
- M_EX_REQ  out  1  bus request to the RAM slave port.
- M_ADDR  out  AW  bus address.
- M_CMD  out  3  bus command: 3'd0 = read, 3'd1 = write. No other codes are issued.
- M_D_WR  out  8  write data.
- M_EX_ACK  in  1  slave acknowledge. A transfer completes in any cycle where REQ and ACK are both high.
- M_D_RD  in  8  slave read data. Valid in the completing cycle of a read.

Behaviour:
- Reset (RST=1 at a clock edge):
  - State goes to IDLE.
  - BUSY=0, DONE=0, M_EX_REQ=0, M_ADDR=0, M_CMD=0, M_D_WR=0.
  - Internal counters and registers are cleared.
  - Reset mid-command aborts immediately. No further bus cycles and no DONE.
- All outputs are registered.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - On START=1, capture OP/SRC/DST/LEN/FILL_VAL.
  - LEN=0 goes to FIN with no bus activity.
  - Otherwise go to WR (FILL) or RD (COPY).
  - START while not in IDLE is ignored and not queued.
- RD (COPY only):
  - REQ=1, CMD=0, ADDR=src pointer.
  - On ACK, latch M_D_RD into the data register, increment the src pointer, go to WR.
- WR:
  - REQ=1, CMD=1, ADDR=dst pointer.
  - D_WR = FILL_VAL (FILL) or the latched read byte (COPY).
  - On ACK, increment the dst pointer and decrement the remaining count.
  - If the count reaches 0, go to FIN. Otherwise go to WR (FILL) or RD (COPY).
- FIN: DONE=1 for exactly one cycle, REQ=0, then IDLE.
- BUSY:
  - High from the cycle after START through the FIN cycle inclusive.
  - Low in IDLE.
- Request holding:
  - While ACK=0, REQ, ADDR, CMD and D_WR hold stable. Wait states are unbounded.
  - REQ never drops without a completed transfer, except on reset.
- Address arithmetic:
  - Pointers are AW bits and wrap modulo 2**AW. For example, DST=31 with AW=5 is followed by address 0.
  - LEN=2**AW touches every address exactly once.
- Latency with ACK tied high, START at cycle 0:
  - First REQ in cycle 1.
  - FILL of N: REQ high cycles 1..N, DONE in cycle N+1.
  - COPY of N: REQ high cycles 1..2N, alternating read/write, DONE in cycle 2N+1.
  - LEN=0: DONE in cycle 1.
- Overlap: COPY is strictly ascending and read-before-write per element.
  - DST > SRC with overlap re-copies already-written data. This is defined behaviour and the caller's responsibility.
  - DST == SRC rewrites identical data.
- FILL never issues reads. COPY never issues two consecutive reads.

Test Plan:
- FILL, ACK=1: START OP=0 DST=4 LEN=3 FILL_VAL=8'hA5 -> writes to addresses 4,5,6 in cycles 1-3; DONE in cycle 4; RAM[4..6]=A5, RAM[3] and RAM[7] unchanged.
- COPY, ACK=1: RAM[0..3]=11,22,33,44; START OP=1 SRC=0 DST=16 LEN=4 -> 8 bus cycles alternating CMD 0/1; DONE in cycle 9; RAM[16..19]=11,22,33,44.
- Wrap and wait states: FILL DST=30 LEN=4 with ACK low on every other cycle -> addresses 30,31,0,1 written; REQ/ADDR/D_WR stable during each wait; exactly 4 writes; one DONE.
- Boundaries: LEN=0 -> DONE in cycle 1, no REQ. LEN=32 (AW=5) FILL 8'h00 -> all 32 addresses cleared, DONE in cycle 33.
- START during BUSY and reset mid-copy: second START mid-command is ignored (RAM matches the single-command result). RST asserted after 3 of 8 cycles -> next cycle REQ=0, BUSY=0, no DONE; a new START then runs normally.

Source files
------------

// File: rtl/ram_block_mover_if.sv
// Bus between the block mover (master) and the command-processing RAM slave port.
// A transfer completes in any cycle where M_EX_REQ and M_EX_ACK are both high.
interface ram_block_mover_if #(
  parameter int AW = 5
) ();
  logic          M_EX_REQ;
  logic [AW-1:0] M_ADDR;
  logic [2:0]    M_CMD;
  logic [7:0]    M_D_WR;
  logic          M_EX_ACK;
  logic [7:0]    M_D_RD;

  modport master (
    output M_EX_REQ, M_ADDR, M_CMD, M_D_WR,
    input  M_EX_ACK, M_D_RD
  );

  modport slave (
    input  M_EX_REQ, M_ADDR, M_CMD, M_D_WR,
    output M_EX_ACK, M_D_RD
  );
endinterface

// File: rtl/ram_block_mover.sv
// Block FILL / COPY engine: turns one START command into a sequence of RAM bus
// transfers and reports completion with a single DONE pulse. All outputs registered.
module ram_block_mover #(
  parameter int AW = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                OP,
  input  logic [AW-1:0]       SRC,
  input  logic [AW-1:0]       DST,
  input  logic [AW:0]         LEN,
  input  logic [7:0]          FILL_VAL,
  output logic                BUSY,
  output logic                DONE,
  ram_block_mover_if.master   m
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [2:0] CMD_RD = 3'd0;
  localparam logic [2:0] CMD_WR = 3'd1;

  state_t        state_q, state_d;
  logic          op_q, op_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    fill_q, fill_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [7:0]    dwr_q, dwr_d;
  logic          xfer_s;

  assign xfer_s = req_q & m.M_EX_ACK;

  // Next-state and next-output computation; bus outputs are set up one cycle
  // ahead so every port is driven straight from a flop.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    req_d   = req_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    dwr_d   = dwr_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d   = OP;
          src_d  = SRC;
          dst_d  = DST;
          cnt_d  = LEN;
          fill_d = FILL_VAL;
          busy_d = 1'b1;
          if (LEN == {(AW+1){1'b0}}) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else if (OP) begin
            state_d = S_RD;
            req_d   = 1'b1;
            addr_d  = SRC;
            cmd_d   = CMD_RD;
          end else begin
            state_d = S_WR;
            req_d   = 1'b1;
            addr_d  = DST;
            cmd_d   = CMD_WR;
            dwr_d   = FILL_VAL;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_RD: begin
        if (xfer_s) begin
          data_d  = m.M_D_RD;
          src_d   = src_q + AW'(1);
          state_d = S_WR;
          addr_d  = dst_q;
          cmd_d   = CMD_WR;
          dwr_d   = m.M_D_RD;
        end else begin
          state_d = S_RD;
        end
      end
      S_WR: begin
        if (xfer_s) begin
          dst_d = dst_q + AW'(1);
          cnt_d = cnt_q - (AW+1)'(1);
          // Last element: drop REQ and raise DONE together on entry to FIN.
          if (cnt_q == (AW+1)'(1)) begin
            state_d = S_FIN;
            req_d   = 1'b0;
            done_d  = 1'b1;
          end else if (op_q) begin
            state_d = S_RD;
            addr_d  = src_q;
            cmd_d   = CMD_RD;
          end else begin
            state_d = S_WR;
            addr_d  = dst_q + AW'(1);
            dwr_d   = fill_q;
          end
        end else begin
          state_d = S_WR;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset that aborts any command.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      src_q   <= {AW{1'b0}};
      dst_q   <= {AW{1'b0}};
      cnt_q   <= {(AW+1){1'b0}};
      fill_q  <= 8'h00;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= {AW{1'b0}};
      cmd_q   <= 3'd0;
      dwr_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      dwr_q   <= dwr_d;
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign m.M_EX_REQ = req_q;
  assign m.M_ADDR   = addr_q;
  assign m.M_CMD    = cmd_q;
  assign m.M_D_WR   = dwr_q;

endmodule

// File: tb/tb_ram_block_mover.sv
// Directed bench for ram_block_mover: a behavioural RAM slave with optional wait
// states, a bus monitor, and hand-computed expected values.
module tb_ram_block_mover;

  logic       clk;
  logic       rst;
  logic       start;
  logic       op_i;
  logic [4:0] src_i;
  logic [4:0] dst_i;
  logic [5:0] len_i;
  logic [7:0] fv_i;
  logic       busy;
  logic       done;

  ram_block_mover_if #(.AW(5)) bus ();

  ram_block_mover #(.AW(5)) dut (
    .CLK      (clk),
    .RST      (rst),
    .START    (start),
    .OP       (op_i),
    .SRC      (src_i),
    .DST      (dst_i),
    .LEN      (len_i),
    .FILL_VAL (fv_i),
    .BUSY     (busy),
    .DONE     (done),
    .m        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model and bus monitor state
  logic [7:0] mem [32];
  logic       bk_we;
  logic [4:0] bk_addr;
  logic [7:0] bk_data;
  logic [4:0] wr_log [$];
  logic [2:0] cmd_log [$];
  int         n_unstable = 0;
  int         n_wait     = 0;
  int         n_done     = 0;
  int         n_consec   = 0;
  logic       prev_pend  = 1'b0;
  logic       last_rd    = 1'b0;
  logic       p_req;
  logic [4:0] p_addr;
  logic [2:0] p_cmd;
  logic [7:0] p_dwr;

  assign bus.M_D_RD = mem[bus.M_ADDR];

  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    if (prev_pend && (bus.M_EX_REQ !== p_req || bus.M_ADDR !== p_addr ||
                      bus.M_CMD !== p_cmd || bus.M_D_WR !== p_dwr))
      n_unstable <= n_unstable + 1;
    if (bus.M_EX_REQ && !bus.M_EX_ACK) n_wait <= n_wait + 1;
    prev_pend <= bus.M_EX_REQ && !bus.M_EX_ACK && !rst;
    p_req  <= bus.M_EX_REQ;
    p_addr <= bus.M_ADDR;
    p_cmd  <= bus.M_CMD;
    p_dwr  <= bus.M_D_WR;
    if (bus.M_EX_REQ && bus.M_EX_ACK && !rst) begin
      cmd_log.push_back(bus.M_CMD);
      if (bus.M_CMD == 3'd1) begin
        wr_log.push_back(bus.M_ADDR);
        mem[bus.M_ADDR] <= bus.M_D_WR;
      end
      if (bus.M_CMD == 3'd0 && last_rd) n_consec <= n_consec + 1;
      last_rd <= (bus.M_CMD == 3'd0);
    end
    if (done) n_done <= n_done + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [4:0] a, input logic [7:0] v);
    bk_we = 1'b1; bk_addr = a; bk_data = v;
    step();
    bk_we = 1'b0;
  endtask

  // Issue one command at cycle 0 and run until DONE (bounded). ack_mode 1 gives
  // ACK only on odd cycles; restart_at>0 pulses a bogus START in that cycle.
  task automatic run_cmd(input logic op, input logic [4:0] src, input logic [4:0] dst,
                         input logic [5:0] len, input logic [7:0] fv, input int ack_mode,
                         input int restart_at, output int done_cyc, output int req_cyc,
                         output logic busy_fin);
    int cyc;
    start = 1'b1; op_i = op; src_i = src; dst_i = dst; len_i = len; fv_i = fv;
    step();
    start = 1'b0;
    cyc = 1; done_cyc = -1; req_cyc = 0; busy_fin = 1'b0;
    while (cyc < 300 && done_cyc < 0) begin
      if (cyc == restart_at) begin
        start = 1'b1; op_i = 1'b0; dst_i = src; len_i = 6'd4; fv_i = 8'hFF;
      end else begin
        start = 1'b0;
      end
      bus.M_EX_ACK = (ack_mode == 1) ? cyc[0] : 1'b1;
      if (bus.M_EX_REQ) req_cyc++;
      if (done) begin
        done_cyc = cyc;
        busy_fin = busy;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    bus.M_EX_ACK = 1'b1;
  endtask

  int         dc, rc, base_w, base_c, done0, wait0, cnt;
  logic       bf;
  logic [7:0] bits;
  logic [31:0] seen;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op_i = 1'b0; src_i = 5'd0; dst_i = 5'd0;
    len_i = 6'd0; fv_i = 8'h00; bk_we = 1'b0; bk_addr = 5'd0; bk_data = 8'h00;
    bus.M_EX_ACK = 1'b1;
    step();
    for (int i = 0; i < 32; i++) bd_write(5'(i), 8'(8'h80 + i));
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req",  bus.M_EX_REQ, 0);
    check("rst_bus",  {bus.M_ADDR, bus.M_CMD, bus.M_D_WR}, 0);
    rst = 1'b0;
    step();

    // FILL 4..6 with A5
    base_w = wr_log.size(); done0 = n_done;
    run_cmd(1'b0, 5'd0, 5'd4, 6'd3, 8'hA5, 0, 0, dc, rc, bf);
    check("fill_done_cyc", dc, 4);
    check("fill_req_cyc", rc, 3);
    check("fill_busy_fin", bf, 1);
    check("fill_busy_idle", busy, 0);
    check("fill_nwr", wr_log.size() - base_w, 3);
    check("fill_a0", wr_log[base_w], 4);
    check("fill_a2", wr_log[base_w+2], 6);
    check("fill_mem", {mem[4], mem[5], mem[6]}, 24'hA5A5A5);
    check("fill_edges", {mem[3], mem[7]}, 16'h8387);
    check("fill_ndone", n_done - done0, 1);

    // LEN=0
    base_w = wr_log.size();
    run_cmd(1'b0, 5'd0, 5'd9, 6'd0, 8'h55, 0, 0, dc, rc, bf);
    check("len0_done_cyc", dc, 1);
    check("len0_req_cyc", rc, 0);
    check("len0_nwr", wr_log.size() - base_w, 0);

    // Wrap with wait states
    base_w = wr_log.size(); done0 = n_done; wait0 = n_wait;
    run_cmd(1'b0, 5'd0, 5'd30, 6'd4, 8'h3C, 1, 0, dc, rc, bf);
    check("wrap_done_cyc", dc, 8);
    check("wrap_nwr", wr_log.size() - base_w, 4);
    check("wrap_addrs", {wr_log[base_w], wr_log[base_w+1], wr_log[base_w+2], wr_log[base_w+3]},
          {5'd30, 5'd31, 5'd0, 5'd1});
    check("wrap_waits", n_wait - wait0, 3);
    check("wrap_stable", n_unstable, 0);
    check("wrap_ndone", n_done - done0, 1);
    check("wrap_mem", {mem[30], mem[31], mem[0], mem[1], mem[2]}, 40'h3C3C3C3C82);

    // LEN=32 clears the whole RAM
    base_w = wr_log.size();
    run_cmd(1'b0, 5'd0, 5'd7, 6'd32, 8'h00, 0, 0, dc, rc, bf);
    check("full_done_cyc", dc, 33);
    check("full_nwr", wr_log.size() - base_w, 32);
    seen = 32'h0; cnt = 0;
    for (int i = base_w; i < wr_log.size(); i++) seen[wr_log[i]] = 1'b1;
    for (int i = 0; i < 32; i++) if (mem[i] != 8'h00) cnt++;
    check("full_seen", seen, 32'hFFFF_FFFF);
    check("full_nonzero", cnt, 0);

    // COPY 0..3 -> 16..19
    bd_write(5'd0, 8'h11); bd_write(5'd1, 8'h22); bd_write(5'd2, 8'h33); bd_write(5'd3, 8'h44);
    base_c = cmd_log.size();
    run_cmd(1'b1, 5'd0, 5'd16, 6'd4, 8'h00, 0, 0, dc, rc, bf);
    check("copy_done_cyc", dc, 9);
    check("copy_req_cyc", rc, 8);
    bits = 8'h00;
    for (int i = 0; i < 8; i++) bits[i] = cmd_log[base_c+i][0];
    check("copy_cmds", bits, 8'hAA);
    check("copy_consec", n_consec, 0);
    check("copy_mem", {mem[16], mem[17], mem[18], mem[19]}, 32'h11223344);

    // Second START mid-command is ignored
    done0 = n_done;
    run_cmd(1'b1, 5'd0, 5'd8, 6'd4, 8'h00, 0, 3, dc, rc, bf);
    check("restart_done_cyc", dc, 9);
    check("restart_mem", {mem[8], mem[9], mem[10], mem[11]}, 32'h11223344);
    check("restart_ndone", n_done - done0, 1);
    step(); step();
    check("restart_idle", {busy, bus.M_EX_REQ}, 0);

    // Reset after 3 of 8 copy cycles
    done0 = n_done; base_w = wr_log.size();
    start = 1'b1; op_i = 1'b1; src_i = 5'd0; dst_i = 5'd20; len_i = 6'd4;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    check("abort_req", bus.M_EX_REQ, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("abort_ndone", n_done - done0, 0);
    check("abort_nwr", wr_log.size() - base_w, 1);
    check("abort_mem", {mem[20], mem[21]}, 16'h1100);

    run_cmd(1'b0, 5'd0, 5'd21, 6'd2, 8'h77, 0, 0, dc, rc, bf);
    check("post_done_cyc", dc, 3);
    check("post_mem", {mem[21], mem[22], mem[23]}, 24'h777700);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
